// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage CPU: drives the four pipeline-latch
// commands, PC enable and halt, and keeps saturating stall statistics.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_mem,
    input  logic             dmemWEN_mem,
    input  logic             branch_taken_mem,
    input  logic             MemRead_ex,
    input  logic [REG_W-1:0] regWSEL_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             halt_wb,
    output logic [1:0]       fd_state,
    output logic [1:0]       de_state,
    output logic [1:0]       em_state,
    output logic [1:0]       mw_state,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] hazard_stall_cnt
);

    localparam logic [1:0] PIPE_ENABLE = 2'b00;
    localparam logic [1:0] PIPE_STALL  = 2'b01;
    localparam logic [1:0] PIPE_NOP    = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_memreq;
    logic             w_loaduse;
    logic             w_wait;
    logic             w_mem_stall;
    logic             w_hazard_stall;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_haz_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_memreq  = dmemREN_mem | dmemWEN_mem;
    assign w_loaduse = MemRead_ex & (regWSEL_ex != '0) &
                       ((regWSEL_ex == rs_id) | (regWSEL_ex == rt_id));

    // Memory stall: either still waiting in MEMWAIT, or a fresh unserviced
    // request in RUN that is not pre-empted by a halt in WB.
    assign w_wait = ((r_state == MEMWAIT) & ~dhit) |
                    ((r_state == RUN) & ~halt_wb & w_memreq & ~dhit);

    always_comb begin
        fd_state       = PIPE_ENABLE;
        de_state       = PIPE_ENABLE;
        em_state       = PIPE_ENABLE;
        mw_state       = PIPE_ENABLE;
        pc_en          = 1'b1;
        halt           = 1'b0;
        w_next_state   = RUN;
        w_mem_stall    = 1'b0;
        w_hazard_stall = 1'b0;

        if (r_state == HALTED) begin
            fd_state     = PIPE_STALL;
            de_state     = PIPE_STALL;
            em_state     = PIPE_STALL;
            mw_state     = PIPE_STALL;
            pc_en        = 1'b0;
            halt         = 1'b1;
            w_next_state = HALTED;
        end else if (w_wait) begin
            fd_state     = PIPE_STALL;
            de_state     = PIPE_STALL;
            em_state     = PIPE_STALL;
            mw_state     = PIPE_NOP;
            pc_en        = 1'b0;
            w_next_state = MEMWAIT;
            w_mem_stall  = 1'b1;
        end else if (halt_wb) begin
            fd_state     = PIPE_STALL;
            de_state     = PIPE_STALL;
            em_state     = PIPE_STALL;
            mw_state     = PIPE_STALL;
            pc_en        = 1'b0;
            halt         = 1'b1;
            w_next_state = HALTED;
        end else if (branch_taken_mem) begin
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
        end else if (w_loaduse) begin
            fd_state       = PIPE_STALL;
            de_state       = PIPE_NOP;
            pc_en          = 1'b0;
            w_hazard_stall = 1'b1;
        end else if (!ihit) begin
            fd_state = PIPE_NOP;
            pc_en    = 1'b0;
        end

        // Reset is asynchronous, so the outputs must follow it without a clock.
        if (!nRST) begin
            fd_state       = PIPE_NOP;
            de_state       = PIPE_NOP;
            em_state       = PIPE_NOP;
            mw_state       = PIPE_NOP;
            pc_en          = 1'b0;
            halt           = 1'b0;
            w_next_state   = RUN;
            w_mem_stall    = 1'b0;
            w_hazard_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= RUN;
            r_mem_cnt <= '0;
            r_haz_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_mem_stall) begin
                r_mem_cnt <= sat_inc(r_mem_cnt);
            end
            if (w_hazard_stall) begin
                r_haz_cnt <= sat_inc(r_haz_cnt);
            end
        end
    end

    assign mem_stall_cnt    = r_mem_cnt;
    assign hazard_stall_cnt = r_haz_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a rule-table reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, dmemREN_mem, dmemWEN_mem, branch_taken_mem;
    logic             MemRead_ex, halt_wb;
    logic [REG_W-1:0] regWSEL_ex, rs_id, rt_id;
    logic [1:0]       fd_state, de_state, em_state, mw_state;
    logic             pc_en, halt;
    logic [CNT_W-1:0] mem_stall_cnt, hazard_stall_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
        .branch_taken_mem(branch_taken_mem), .MemRead_ex(MemRead_ex),
        .regWSEL_ex(regWSEL_ex), .rs_id(rs_id), .rt_id(rt_id), .halt_wb(halt_wb),
        .fd_state(fd_state), .de_state(de_state), .em_state(em_state),
        .mw_state(mw_state), .pc_en(pc_en), .halt(halt),
        .mem_stall_cnt(mem_stall_cnt), .hazard_stall_cnt(hazard_stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: 0=running, 1=waiting on memory, 2=halted
    int mdl_mode = 0;
    int mdl_mem  = 0;
    int mdl_haz  = 0;

    // Expected {fd, de, em, mw, pc_en, halt} for each outcome:
    // 0 reset, 1 halt, 2 mem wait, 3 flush, 4 load-use, 5 fetch miss, 6 run, 7 halted
    logic [9:0] rtab [8];
    initial begin
        rtab[0] = 10'b10_10_10_10_0_0;
        rtab[1] = 10'b01_01_01_01_0_1;
        rtab[2] = 10'b01_01_01_10_0_0;
        rtab[3] = 10'b10_10_10_00_1_0;
        rtab[4] = 10'b01_10_00_00_0_0;
        rtab[5] = 10'b10_00_00_00_0_0;
        rtab[6] = 10'b00_00_00_00_1_0;
        rtab[7] = 10'b01_01_01_01_0_1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int pick_rule();
        bit lu;
        lu = MemRead_ex && (regWSEL_ex != 0) && (regWSEL_ex == rs_id || regWSEL_ex == rt_id);
        if (!nRST) return 0;
        if (mdl_mode == 2) return 7;
        if (mdl_mode == 1 && !dhit) return 2;
        if (halt_wb) return 1;
        if ((dmemREN_mem || dmemWEN_mem) && !dhit) return 2;
        if (branch_taken_mem) return 3;
        if (lu) return 4;
        if (!ihit) return 5;
        return 6;
    endfunction

    // Inputs are already driven (just after a rising edge); check, then advance one clock.
    task automatic step();
        int r;
        #2;
        if (!nRST) begin
            mdl_mode = 0; mdl_mem = 0; mdl_haz = 0;
        end
        r = pick_rule();
        chk("outs", 32'({fd_state, de_state, em_state, mw_state, pc_en, halt}), 32'(rtab[r]));
        chk("mem_stall_cnt", 32'(mem_stall_cnt), 32'(mdl_mem));
        chk("hazard_stall_cnt", 32'(hazard_stall_cnt), 32'(mdl_haz));
        @(posedge CLK);
        if (nRST) begin
            if (r == 1 || r == 7) mdl_mode = 2;
            else if (r == 2) mdl_mode = 1;
            else mdl_mode = 0;
            if (r == 2 && mdl_mem < CMAX) mdl_mem++;
            if (r == 4 && mdl_haz < CMAX) mdl_haz++;
        end
        #1;
    endtask

    task automatic drive(input logic rn, input logic ih, input logic dh, input logic ren,
                         input logic wen, input logic br, input logic mr,
                         input logic [REG_W-1:0] ws, input logic [REG_W-1:0] rs,
                         input logic [REG_W-1:0] rt, input logic hw);
        nRST = rn; ihit = ih; dhit = dh; dmemREN_mem = ren; dmemWEN_mem = wen;
        branch_taken_mem = br; MemRead_ex = mr; regWSEL_ex = ws; rs_id = rs; rt_id = rt;
        halt_wb = hw;
        step();
    endtask

    initial begin
        // reset with busy inputs
        drive(0, 1, 0, 1, 0, 1, 1, 5, 5, 5, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // plain running
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        // load waiting 3 cycles then completing
        repeat (3) drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mem_after_3", 32'(mem_stall_cnt), 32'd3);
        // same-cycle dhit: no stall
        drive(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // load-use on rt, then with r0 destination
        drive(1, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("haz_after_1", 32'(hazard_stall_cnt), 32'd1);
        // branch beats load-use and fetch miss
        drive(1, 0, 0, 0, 0, 1, 1, 3, 3, 0, 0);
        // store waiting with branch pending, then dhit
        repeat (2) drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        // fetch miss
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // hazard counter saturation
        repeat (CMAX + 3) drive(1, 1, 0, 0, 0, 0, 1, 7, 7, 2, 0);
        // halt, then further stimulus is ignored
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 4, 4, 4, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset asserted while waiting on memory
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0),
                  REG_W'($urandom_range(0, 3)),
                  REG_W'($urandom_range(0, 3)),
                  REG_W'($urandom_range(0, 3)),
                  ($urandom_range(0, 79) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It produces the per-latch state commands (fd_state, de_state, em_state, mw_state) that the IF/ID, ID/EX, EX/MEM and MEM/WB latches consume. It also produces the PC enable and the halt output. It resolves memory wait, branch flush, load-use and fetch-miss hazards through a small FSM, and it keeps saturating stall statistics.

Parameters:
CNT_W, 16, width of the saturating stall counters
REG_W, 5, register-select width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
dmemREN_mem  in  1  load in MEM stage
dmemWEN_mem  in  1  store in MEM stage
branch_taken_mem  in  1  taken branch/jump resolved in MEM
MemRead_ex  in  1  load in EX stage
regWSEL_ex  in  REG_W  destination register of EX instruction
rs_id  in  REG_W  ID source register rs
rt_id  in  REG_W  ID source register rt
halt_wb  in  1  halt instruction in WB
fd_state  out  2  IF/ID latch command
de_state  out  2  ID/EX latch command
em_state  out  2  EX/MEM latch command
mw_state  out  2  MEM/WB latch command
pc_en  out  1  PC update enable
halt  out  1  CPU halted
mem_stall_cnt  out  CNT_W  cycles spent in MEMWAIT
hazard_stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Clock CLK. Reset nRST is asynchronous and active-low.
- Latch-command encoding (cpu_types_pkg): PIPE_ENABLE=2'b00, PIPE_STALL=2'b01 (hold), PIPE_NOP=2'b10 (load bubble).
- While nRST is low: FSM=RUN; all four states=PIPE_NOP; pc_en=0; halt=0; both counters=0.
- FSM states: RUN, MEMWAIT, HALTED. Outputs are combinational from the FSM state and the inputs. Transitions occur on the CLK rising edge.
- memreq = dmemREN_mem | dmemWEN_mem.
- loaduse = MemRead_ex & (regWSEL_ex != 0) & (regWSEL_ex == rs_id | regWSEL_ex == rt_id).
- Evaluation in RUN, and in MEMWAIT once dhit=1. First match wins:
  1. halt_wb: all four states PIPE_STALL; pc_en=0; halt=1; next state HALTED.
  2. memreq & !dhit: fd, de and em PIPE_STALL; mw PIPE_NOP; pc_en=0; next state MEMWAIT.
  3. branch_taken_mem: fd, de and em PIPE_NOP; mw PIPE_ENABLE; pc_en=1.
  4. loaduse: fd PIPE_STALL; de PIPE_NOP; em and mw PIPE_ENABLE; pc_en=0.
  5. !ihit: fd PIPE_NOP; de, em and mw PIPE_ENABLE; pc_en=0.
  6. Otherwise: all PIPE_ENABLE; pc_en=1.
- MEMWAIT with dhit=0: outputs as in rule 2; remain in MEMWAIT.
- MEMWAIT with dhit=1: return to RUN. That same cycle, rules 1 and 3-6 apply.
- A dhit in the same cycle as the request means no stall and no MEMWAIT entry.
- A branch_taken_mem arriving during MEMWAIT is held by the stalled EX/MEM latch and is applied on the dhit cycle.
- HALTED: all states PIPE_STALL; pc_en=0; halt=1. Only nRST exits this state.
- mem_stall_cnt increments on every cycle that rule 2 outputs are driven (in RUN or MEMWAIT). It saturates at all-ones.
- hazard_stall_cnt increments on every cycle rule 4 is selected. It saturates at all-ones.
- Neither counter increments in HALTED.
- Reset asserted mid-MEMWAIT: immediate return to the reset outputs. No pending state is retained.

Test Plan:
- Reset, then ihit=1 with no hazards -> all states 00, pc_en=1, counters 0; during nRST=0 all states 10, pc_en=0.
- Load in MEM with dhit=0 for 3 cycles, then 1 -> fd/de/em=01, mw=10, pc_en=0 for 3 cycles; all 00 on the 4th cycle; mem_stall_cnt=3.
- MemRead_ex=1, regWSEL_ex=5, rt_id=5 -> fd=01, de=10, em/mw=00, pc_en=0; hazard_stall_cnt=1. Repeat with regWSEL_ex=0 -> no stall.
- branch_taken_mem=1 together with loaduse and ihit=0 -> fd/de/em=10, mw=00, pc_en=1.
- Store with dhit=0 plus branch_taken_mem=1 for 2 cycles, then dhit=1 -> 2 cycles of rule-2 outputs, then flush outputs on the dhit cycle.
- halt_wb=1 -> halt=1 and all states 01 in the same cycle; stays halted with halt_wb=0 and other stimulus; counters frozen; nRST clears.
